// File: rtl/msrv32_load_store_unit.sv
// ---------------------------------------------------------------------------
// msrv32_load_store_unit
//
// Data-memory load/store unit fed from the stage-2 pipeline register.
// It issues one req/ack transaction at a time, builds byte-lane masks and
// lane-replicated store data, and aligns and extends load data for writeback.
// The pipeline is stalled while a transaction is outstanding.
//
// Optional build macro: MSRV32_LSU_TIMEOUT_EN
//   defined   -> an ack wait longer than TIMEOUT_CYCLES BUSY cycles aborts the
//                transaction and pulses bus_error_out
//   undefined -> BUSY waits for ack indefinitely, bus_error_out is tied to 0
//
// Ports
//   clk_in            clock, rising edge
//   reset_in          synchronous active-high reset
//   iadder_in         effective byte address
//   rs2_in            store source data
//   load_size_in      00 byte, 01 half, 10/11 word
//   load_unsigned_in  1 = zero-extend, 0 = sign-extend
//   mem_rd_req_in     load request (sampled in IDLE)
//   mem_wr_req_in     store request (sampled in IDLE, wins over load)
//   dmem_ack_in       memory completion
//   dmem_rdata_in     memory read word
//   dmem_addr_out     word-aligned address
//   dmem_wr_data_out  lane-replicated store data
//   dmem_wr_mask_out  byte-enable mask (0 on loads)
//   dmem_rd_req_out   load request to memory
//   dmem_wr_req_out   store request to memory
//   load_data_out     aligned, extended load result (held between loads)
//   load_valid_out    one-cycle pulse with a new load result
//   misaligned_out    one-cycle pulse for a rejected misaligned access
//   bus_error_out     one-cycle pulse on ack timeout
//   stall_out         high while a transaction is outstanding
//
// state | meaning
// IDLE  | waiting for a request; misaligned requests are rejected here
// BUSY  | request on the bus, waiting for dmem_ack_in
// ---------------------------------------------------------------------------
module msrv32_load_store_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk_in,
   input  logic        reset_in,
   input  logic [31:0] iadder_in,
   input  logic [31:0] rs2_in,
   input  logic [1:0]  load_size_in,
   input  logic        load_unsigned_in,
   input  logic        mem_rd_req_in,
   input  logic        mem_wr_req_in,
   input  logic        dmem_ack_in,
   input  logic [31:0] dmem_rdata_in,
   output logic [31:0] dmem_addr_out,
   output logic [31:0] dmem_wr_data_out,
   output logic [3:0]  dmem_wr_mask_out,
   output logic        dmem_rd_req_out,
   output logic        dmem_wr_req_out,
   output logic [31:0] load_data_out,
   output logic        load_valid_out,
   output logic        misaligned_out,
   output logic        bus_error_out,
   output logic        stall_out
);

   // The timeout counter needs at least two distinct values to be meaningful.
   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("msrv32_load_store_unit: TIMEOUT_CYCLES must be at least 2");
   end

   typedef enum logic {IDLE, BUSY} state_t;

   state_t      state;
   logic [1:0]  lane_q;
   logic [1:0]  size_q;
   logic        unsigned_q;

   logic        req_any;
   logic        misaligned_req;
   logic [31:0] st_data;
   logic [3:0]  st_mask;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_ext;

`ifdef MSRV32_LSU_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   logic [CNT_W-1:0] to_cnt;
`endif

   assign req_any = mem_wr_req_in | mem_rd_req_in;

   always_comb begin
      misaligned_req = 1'b0;
      case (load_size_in)
         2'b00:   misaligned_req = 1'b0;
         2'b01:   misaligned_req = iadder_in[0];
         default: misaligned_req = |iadder_in[1:0];
      endcase
   end

   always_comb begin
      st_data = rs2_in;
      st_mask = 4'b1111;
      case (load_size_in)
         2'b00: begin
            st_data = {4{rs2_in[7:0]}};
            st_mask = 4'b0001 << iadder_in[1:0];
         end
         2'b01: begin
            st_data = {2{rs2_in[15:0]}};
            st_mask = iadder_in[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            st_data = rs2_in;
            st_mask = 4'b1111;
         end
      endcase
   end

   // Lane selection uses the address captured at request time, since the
   // pipeline may have moved iadder_in on by the time ack arrives.
   always_comb begin
      byte_sel = 8'h00;
      case (lane_q)
         2'b00: byte_sel = dmem_rdata_in[7:0];
         2'b01: byte_sel = dmem_rdata_in[15:8];
         2'b10: byte_sel = dmem_rdata_in[23:16];
         2'b11: byte_sel = dmem_rdata_in[31:24];
         default: byte_sel = 8'h00;
      endcase
      half_sel = lane_q[1] ? dmem_rdata_in[31:16] : dmem_rdata_in[15:0];
      case (size_q)
         2'b00:   load_ext = {{24{~unsigned_q & byte_sel[7]}}, byte_sel};
         2'b01:   load_ext = {{16{~unsigned_q & half_sel[15]}}, half_sel};
         default: load_ext = dmem_rdata_in;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         state            <= IDLE;
         lane_q           <= 2'b00;
         size_q           <= 2'b00;
         unsigned_q       <= 1'b0;
         dmem_addr_out    <= '0;
         dmem_wr_data_out <= '0;
         dmem_wr_mask_out <= '0;
         dmem_rd_req_out  <= 1'b0;
         dmem_wr_req_out  <= 1'b0;
         load_data_out    <= '0;
         load_valid_out   <= 1'b0;
         misaligned_out   <= 1'b0;
         stall_out        <= 1'b0;
`ifdef MSRV32_LSU_TIMEOUT_EN
         bus_error_out    <= 1'b0;
         to_cnt           <= '0;
`endif
      end else begin
         load_valid_out <= 1'b0;
         misaligned_out <= 1'b0;
`ifdef MSRV32_LSU_TIMEOUT_EN
         bus_error_out  <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (req_any) begin
                  if (misaligned_req) begin
                     misaligned_out <= 1'b1;
                  end else begin
                     state            <= BUSY;
                     lane_q           <= iadder_in[1:0];
                     size_q           <= load_size_in;
                     unsigned_q       <= load_unsigned_in;
                     dmem_addr_out    <= {iadder_in[31:2], 2'b00};
                     // Store wins when both requests are present.
                     dmem_wr_req_out  <= mem_wr_req_in;
                     dmem_rd_req_out  <= ~mem_wr_req_in;
                     dmem_wr_data_out <= mem_wr_req_in ? st_data : 32'h0;
                     dmem_wr_mask_out <= mem_wr_req_in ? st_mask : 4'b0000;
                     stall_out        <= 1'b1;
`ifdef MSRV32_LSU_TIMEOUT_EN
                     to_cnt           <= '0;
`endif
                  end
               end
            end
            BUSY: begin
               if (dmem_ack_in) begin
                  state           <= IDLE;
                  dmem_rd_req_out <= 1'b0;
                  dmem_wr_req_out <= 1'b0;
                  stall_out       <= 1'b0;
                  if (dmem_rd_req_out) begin
                     load_data_out  <= load_ext;
                     load_valid_out <= 1'b1;
                  end
               end
`ifdef MSRV32_LSU_TIMEOUT_EN
               else if (to_cnt == TO_LAST) begin
                  state           <= IDLE;
                  dmem_rd_req_out <= 1'b0;
                  dmem_wr_req_out <= 1'b0;
                  stall_out       <= 1'b0;
                  bus_error_out   <= 1'b1;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifndef MSRV32_LSU_TIMEOUT_EN
   assign bus_error_out = 1'b0;
`endif

endmodule

// File: tb/tb_msrv32_load_store_unit.sv
module tb_msrv32_load_store_unit;

   logic        clk_in = 1'b0;
   logic        reset_in;
   logic [31:0] iadder_in;
   logic [31:0] rs2_in;
   logic [1:0]  load_size_in;
   logic        load_unsigned_in;
   logic        mem_rd_req_in;
   logic        mem_wr_req_in;
   logic        dmem_ack_in;
   logic [31:0] dmem_rdata_in;
   logic [31:0] dmem_addr_out;
   logic [31:0] dmem_wr_data_out;
   logic [3:0]  dmem_wr_mask_out;
   logic        dmem_rd_req_out;
   logic        dmem_wr_req_out;
   logic [31:0] load_data_out;
   logic        load_valid_out;
   logic        misaligned_out;
   logic        bus_error_out;
   logic        stall_out;

   int n_cmp = 0;
   int n_err = 0;

   msrv32_load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
      .clk_in           (clk_in),
      .reset_in         (reset_in),
      .iadder_in        (iadder_in),
      .rs2_in           (rs2_in),
      .load_size_in     (load_size_in),
      .load_unsigned_in (load_unsigned_in),
      .mem_rd_req_in    (mem_rd_req_in),
      .mem_wr_req_in    (mem_wr_req_in),
      .dmem_ack_in      (dmem_ack_in),
      .dmem_rdata_in    (dmem_rdata_in),
      .dmem_addr_out    (dmem_addr_out),
      .dmem_wr_data_out (dmem_wr_data_out),
      .dmem_wr_mask_out (dmem_wr_mask_out),
      .dmem_rd_req_out  (dmem_rd_req_out),
      .dmem_wr_req_out  (dmem_wr_req_out),
      .load_data_out    (load_data_out),
      .load_valid_out   (load_valid_out),
      .misaligned_out   (misaligned_out),
      .bus_error_out    (bus_error_out),
      .stall_out        (stall_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Load with ack in the first BUSY cycle; checks bus phase and result phase.
   task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                          input logic uns, input logic [31:0] rdata, input logic [31:0] exp);
      iadder_in = addr; load_size_in = size; load_unsigned_in = uns; mem_rd_req_in = 1'b1;
      tick();
      mem_rd_req_in = 1'b0;
      chk({tag, "_rdreq"}, dmem_rd_req_out, 1'b1);
      chk({tag, "_mask"}, dmem_wr_mask_out, 4'b0000);
      chk({tag, "_addr"}, dmem_addr_out, {addr[31:2], 2'b00});
      chk({tag, "_stall"}, stall_out, 1'b1);
      dmem_ack_in = 1'b1; dmem_rdata_in = rdata;
      tick();
      dmem_ack_in = 1'b0;
      chk({tag, "_data"}, load_data_out, exp);
      chk({tag, "_valid"}, load_valid_out, 1'b1);
      chk({tag, "_stall_off"}, stall_out, 1'b0);
      chk({tag, "_rdreq_off"}, dmem_rd_req_out, 1'b0);
      dmem_rdata_in = 32'h0;
      tick();
      chk({tag, "_valid_off"}, load_valid_out, 1'b0);
      chk({tag, "_hold"}, load_data_out, exp);
   endtask

   initial begin
      reset_in = 1'b1; iadder_in = '0; rs2_in = '0; load_size_in = 2'b00;
      load_unsigned_in = 1'b0; mem_rd_req_in = 1'b0; mem_wr_req_in = 1'b0;
      dmem_ack_in = 1'b0; dmem_rdata_in = '0;
      tick(); tick();
      chk("rst_addr", dmem_addr_out, 32'h0);
      chk("rst_wdata", dmem_wr_data_out, 32'h0);
      chk("rst_mask", dmem_wr_mask_out, 4'h0);
      chk("rst_reqs", {dmem_rd_req_out, dmem_wr_req_out}, 2'b00);
      chk("rst_ldata", load_data_out, 32'h0);
      chk("rst_pulses", {load_valid_out, misaligned_out, bus_error_out, stall_out}, 4'b0000);
      reset_in = 1'b0;
      tick();

      // Byte store to the top lane.
      iadder_in = 32'h0000_1003; rs2_in = 32'hAABB_CCDD; load_size_in = 2'b00; mem_wr_req_in = 1'b1;
      tick();
      mem_wr_req_in = 1'b0;
      chk("sb_addr", dmem_addr_out, 32'h0000_1000);
      chk("sb_mask", dmem_wr_mask_out, 4'b1000);
      chk("sb_wdata", dmem_wr_data_out, 32'hDDDD_DDDD);
      chk("sb_wrreq", {dmem_wr_req_out, dmem_rd_req_out}, 2'b10);
      chk("sb_stall", stall_out, 1'b1);
      dmem_ack_in = 1'b1;
      tick();
      dmem_ack_in = 1'b0;
      chk("sb_stall_off", stall_out, 1'b0);
      chk("sb_wrreq_off", dmem_wr_req_out, 1'b0);
      chk("sb_no_valid", load_valid_out, 1'b0);
      tick();

      do_load("lb_s",  32'h0000_1001, 2'b00, 1'b0, 32'h1234_8056, 32'hFFFF_FF80);
      do_load("lb_u",  32'h0000_1001, 2'b00, 1'b1, 32'h1234_8056, 32'h0000_0080);
      do_load("lhu",   32'h0000_1002, 2'b01, 1'b1, 32'hBEEF_1234, 32'h0000_BEEF);
      do_load("lh_s",  32'h0000_1002, 2'b01, 1'b0, 32'hBEEF_1234, 32'hFFFF_BEEF);
      do_load("lh_lo", 32'h0000_1000, 2'b01, 1'b0, 32'hBEEF_1234, 32'h0000_1234);
      do_load("lw",    32'h0000_1004, 2'b10, 1'b0, 32'hCAFE_F00D, 32'hCAFE_F00D);

      // Misaligned word load.
      iadder_in = 32'h0000_1002; load_size_in = 2'b10; mem_rd_req_in = 1'b1;
      tick();
      mem_rd_req_in = 1'b0;
      chk("mis_w_pulse", misaligned_out, 1'b1);
      chk("mis_w_rdreq", dmem_rd_req_out, 1'b0);
      chk("mis_w_stall", stall_out, 1'b0);
      tick();
      chk("mis_w_pulse_off", misaligned_out, 1'b0);
      chk("mis_w_stall2", stall_out, 1'b0);

      // Misaligned half store.
      iadder_in = 32'h0000_1001; load_size_in = 2'b01; mem_wr_req_in = 1'b1;
      tick();
      mem_wr_req_in = 1'b0;
      chk("mis_h_pulse", misaligned_out, 1'b1);
      chk("mis_h_wrreq", dmem_wr_req_out, 1'b0);
      tick();

      // Both requests: store wins; half store to upper half.
      iadder_in = 32'h0000_1002; rs2_in = 32'h0000_BEEF; load_size_in = 2'b01;
      mem_wr_req_in = 1'b1; mem_rd_req_in = 1'b1;
      tick();
      mem_wr_req_in = 1'b0; mem_rd_req_in = 1'b0;
      chk("both_reqs", {dmem_wr_req_out, dmem_rd_req_out}, 2'b10);
      chk("sh_wdata", dmem_wr_data_out, 32'hBEEF_BEEF);
      chk("sh_mask", dmem_wr_mask_out, 4'b1100);
      dmem_ack_in = 1'b1;
      tick();
      dmem_ack_in = 1'b0;
      chk("both_done", stall_out, 1'b0);
      tick();

      // Word store with ack delayed; a load during BUSY must be ignored.
      iadder_in = 32'h0000_2000; rs2_in = 32'h1122_3344; load_size_in = 2'b10; mem_wr_req_in = 1'b1;
      tick();
      mem_wr_req_in = 1'b0; mem_rd_req_in = 1'b1; iadder_in = 32'h0000_3000; rs2_in = 32'h0;
      for (int i = 0; i < 3; i++) begin
         chk("sw_stall", stall_out, 1'b1);
         chk("sw_reqs", {dmem_wr_req_out, dmem_rd_req_out}, 2'b10);
         chk("sw_addr", dmem_addr_out, 32'h0000_2000);
         chk("sw_wdata", dmem_wr_data_out, 32'h1122_3344);
         chk("sw_mask", dmem_wr_mask_out, 4'b1111);
         if (i == 2) dmem_ack_in = 1'b1;
         tick();
      end
      dmem_ack_in = 1'b0; mem_rd_req_in = 1'b0;
      chk("sw_stall_off", stall_out, 1'b0);
      chk("sw_reqs_off", {dmem_wr_req_out, dmem_rd_req_out}, 2'b00);
      tick();
      chk("sw_no_late_rd", dmem_rd_req_out, 1'b0);

      // Ack in IDLE is ignored.
      dmem_ack_in = 1'b1; dmem_rdata_in = 32'hFFFF_FFFF;
      tick();
      dmem_ack_in = 1'b0; dmem_rdata_in = 32'h0;
      chk("idle_ack_valid", load_valid_out, 1'b0);
      chk("idle_ack_stall", stall_out, 1'b0);
      chk("idle_ack_data", load_data_out, 32'hCAFE_F00D);

      // Reset during BUSY, then a stray ack.
      iadder_in = 32'h0000_1000; load_size_in = 2'b10; mem_rd_req_in = 1'b1;
      tick();
      mem_rd_req_in = 1'b0;
      chk("rstb_busy", stall_out, 1'b1);
      reset_in = 1'b1;
      tick();
      reset_in = 1'b0;
      chk("rstb_reqs", {dmem_rd_req_out, dmem_wr_req_out, stall_out}, 3'b000);
      chk("rstb_addr", dmem_addr_out, 32'h0);
      dmem_ack_in = 1'b1; dmem_rdata_in = 32'h5555_AAAA;
      tick();
      dmem_ack_in = 1'b0;
      chk("rstb_no_valid", load_valid_out, 1'b0);
      chk("rstb_ldata", load_data_out, 32'h0);
      chk("rstb_stall", stall_out, 1'b0);
      tick();

      // Request with no ack.
      iadder_in = 32'h0000_1000; rs2_in = 32'h0000_0011; load_size_in = 2'b00; mem_wr_req_in = 1'b1;
      tick();
      mem_wr_req_in = 1'b0;
`ifdef MSRV32_LSU_TIMEOUT_EN
      for (int i = 0; i < 4; i++) begin
         chk("to_stall", stall_out, 1'b1);
         chk("to_berr_low", bus_error_out, 1'b0);
         tick();
      end
      chk("to_berr", bus_error_out, 1'b1);
      chk("to_stall_off", stall_out, 1'b0);
      chk("to_reqs_off", {dmem_wr_req_out, dmem_rd_req_out}, 2'b00);
      tick();
      chk("to_berr_off", bus_error_out, 1'b0);
`else
      for (int i = 0; i < 20; i++) begin
         chk("wait_stall", stall_out, 1'b1);
         chk("wait_berr", bus_error_out, 1'b0);
         tick();
      end
      dmem_ack_in = 1'b1;
      tick();
      dmem_ack_in = 1'b0;
      chk("wait_stall_off", stall_out, 1'b0);
      chk("wait_berr_end", bus_error_out, 1'b0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
